muldiv_unit: RTL

//   Iterative RV32M/RV64M multiply/divide execute unit. It is the parametrised,

---
 rtl/muldiv_unit.sv | 140 ++++++++++++++
 1 files changed

// File: rtl/muldiv_unit.sv
// rtl/muldiv_unit.sv - iterative RV32M/RV64M multiply/divide unit
// Shift-add multiply and restoring divide on operand magnitudes, with a single sign-fix cycle.
module muldiv_unit #(
   parameter int XLEN = 32
) (
   input  logic            clock,
   input  logic            reset_n,
   input  logic            start,
   input  logic [2:0]      funct3,
   input  logic [XLEN-1:0] rs1,
   input  logic [XLEN-1:0] rs2,
   output logic            busy,
   output logic            done,
   output logic [XLEN-1:0] result
);

   localparam int CNT_W = $clog2(XLEN) + 1;

   typedef enum logic [1:0] {S_IDLE, S_CALC, S_FIX, S_DONE} state_t;

   state_t              r_state;
   state_t              w_next;
   logic [CNT_W-1:0]    r_cnt;
   logic [2:0]          r_op;
   logic                r_sign_a;
   logic                r_sign_b;
   logic [XLEN-1:0]     r_opa;
   logic [XLEN-1:0]     r_opb;
   logic [2*XLEN-1:0]   r_prod;
   logic [XLEN-1:0]     r_rem;
   logic [XLEN-1:0]     r_result;

   logic                w_accept;
   logic                w_a_signed;
   logic                w_b_signed;
   logic                w_sa;
   logic                w_sb;
   logic [XLEN-1:0]     w_mag_a;
   logic [XLEN-1:0]     w_mag_b;
   logic                w_div0;
   logic                w_ovf;
   logic                w_short;
   logic [XLEN-1:0]     w_short_res;
   logic [XLEN:0]       w_msum;
   logic [XLEN:0]       w_shift;
   logic                w_ge;
   logic [XLEN-1:0]     w_sub;
   logic [2*XLEN-1:0]   w_prod_fix;
   logic [XLEN-1:0]     w_quo;
   logic [XLEN-1:0]     w_rmd;
   logic [XLEN-1:0]     w_fix_res;

   assign w_accept   = start & ((r_state == S_IDLE) | (r_state == S_DONE));
   // rs1 is signed for MUL/MULH/MULHSU/DIV/REM; rs2 only for MUL/MULH/DIV/REM
   assign w_a_signed = funct3[2] ? ~funct3[0] : (funct3[1:0] != 2'b11);
   assign w_b_signed = funct3[2] ? ~funct3[0] : ~funct3[1];
   assign w_sa       = w_a_signed & rs1[XLEN-1];
   assign w_sb       = w_b_signed & rs2[XLEN-1];
   assign w_mag_a    = w_sa ? -rs1 : rs1;
   assign w_mag_b    = w_sb ? -rs2 : rs2;

   assign w_div0      = funct3[2] & (rs2 == '0);
   assign w_ovf       = funct3[2] & ~funct3[0] & (rs1 == {1'b1, {(XLEN-1){1'b0}}}) & (&rs2);
   assign w_short     = w_div0 | w_ovf;
   assign w_short_res = w_div0 ? (funct3[1] ? rs1 : '1) : (funct3[1] ? '0 : rs1);

   assign w_msum  = {1'b0, r_prod[2*XLEN-1:XLEN]} + (r_prod[0] ? {1'b0, r_opa} : '0);
   assign w_shift = {r_rem, r_prod[XLEN-1]};
   assign w_ge    = w_shift >= {1'b0, r_opb};
   assign w_sub   = w_shift[XLEN-1:0] - r_opb;

   assign w_prod_fix = (r_sign_a ^ r_sign_b) ? -r_prod : r_prod;
   assign w_quo      = (r_sign_a ^ r_sign_b) ? -r_prod[XLEN-1:0] : r_prod[XLEN-1:0];
   assign w_rmd      = r_sign_a ? -r_rem : r_rem;

   always_comb begin
      w_fix_res = w_rmd;
      case (r_op)
         3'b000:                 w_fix_res = w_prod_fix[XLEN-1:0];
         3'b001, 3'b010, 3'b011: w_fix_res = w_prod_fix[2*XLEN-1:XLEN];
         3'b100, 3'b101:         w_fix_res = w_quo;
         default:                w_fix_res = w_rmd;
      endcase
   end

   always_comb begin
      w_next = r_state;
      case (r_state)
         S_IDLE, S_DONE: w_next = start ? (w_short ? S_DONE : S_CALC) : S_IDLE;
         S_CALC:         if (r_cnt == CNT_W'(1)) w_next = S_FIX;
         S_FIX:          w_next = S_DONE;
         default:        w_next = S_IDLE;
      endcase
   end

   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) r_state <= S_IDLE;
      else          r_state <= w_next;
   end

   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         r_cnt    <= '0;
         r_op     <= '0;
         r_sign_a <= 1'b0;
         r_sign_b <= 1'b0;
         r_opa    <= '0;
         r_opb    <= '0;
         r_prod   <= '0;
         r_rem    <= '0;
         r_result <= '0;
      end else if (w_accept) begin
         r_op     <= funct3;
         r_sign_a <= w_sa;
         r_sign_b <= w_sb;
         r_opa    <= w_mag_a;
         r_opb    <= w_mag_b;
         r_cnt    <= CNT_W'(XLEN);
         r_rem    <= '0;
         // low half holds the multiplier, or the dividend that becomes the quotient
         r_prod   <= {{XLEN{1'b0}}, (funct3[2] ? w_mag_a : w_mag_b)};
         if (w_short) r_result <= w_short_res;
      end else if (r_state == S_CALC) begin
         r_cnt <= r_cnt - 1'b1;
         if (r_op[2]) begin
            r_rem              <= w_ge ? w_sub : w_shift[XLEN-1:0];
            r_prod[XLEN-1:0]   <= {r_prod[XLEN-2:0], w_ge};
         end else begin
            r_prod <= {w_msum, r_prod[XLEN-1:1]};
         end
      end else if (r_state == S_FIX) begin
         r_result <= w_fix_res;
      end
   end

   assign busy   = (r_state == S_CALC) | (r_state == S_FIX);
   assign done   = (r_state == S_DONE);
   assign result = r_result;

endmodule
